pulse_stretch: RTL
==================

# pulse_stretch

Converts single-cycle event pulses (such as those produced by the board's edge detectors) into a level output held for a programmable number of cycles, followed by a minimum de-asserted gap. It drives human-visible or slow-sampled indicators, for example LEDs or GPIO strobes, from one-cycle events. It is the inverse of edge detection: pulse in, level out. Optional retrigger and single-entry pending logic control how overlapping events are handled.

## Interface
- WIDTH_CYCLES, 16: cycles `level` stays asserted per trigger; must be >= 1.
- GAP_CYCLES, 4: minimum cycles `level` stays de-asserted after an assertion; 0 allowed.
- RETRIGGER, 1: 1 = a trigger while asserted reloads the width counter; 0 = that trigger is dropped.
- ACTIVE_LOW, 0: output polarity of `level`; 1 = asserted low.

- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- pulse  input  1  trigger, active-high, sampled every rising edge of clk. A level held high for N cycles counts as N triggers.
- level  output  1  stretched output, polarity set by ACTIVE_LOW, registered.
- busy  output  1  high when not IDLE (ACTIVE or GAP), registered.
- dropped  output  1  one-cycle flag: a sampled trigger was discarded, registered.

## Operation
- States: IDLE, ACTIVE, GAP. Down-counter width is $clog2(max(WIDTH_CYCLES, GAP_CYCLES)+1). There is also a `pending` flag.
- IDLE:
  - pulse=1 -> ACTIVE, counter loaded with WIDTH_CYCLES-1.
- ACTIVE:
  - `level` is asserted.
  - pulse=1 with RETRIGGER=1 -> counter reloaded with WIDTH_CYCLES-1, including on the last ACTIVE cycle.
  - pulse=1 with RETRIGGER=0 -> trigger ignored; `dropped`=1 next cycle.
  - Counter==0 with no reload -> GAP (counter = GAP_CYCLES-1). If GAP_CYCLES=0, go to IDLE instead.
- GAP:
  - `level` is de-asserted.
  - pulse=1 with pending=0 -> pending set.
  - pulse=1 with pending=1 -> trigger ignored; `dropped`=1 next cycle.
  - Counter==0 -> ACTIVE (counter = WIDTH_CYCLES-1, pending cleared) if pending=1 or pulse=1 this cycle. Otherwise -> IDLE.
- Output encoding: `level` = (state==ACTIVE) XOR ACTIVE_LOW. `busy` = (state!=IDLE).
- Counter arithmetic is unsigned. The counter never decrements below 0, so no wrap-around.
- Reset, asynchronous and effective immediately, including mid-ACTIVE or mid-GAP:
  - state=IDLE, counter=0, pending=0
  - `level`=ACTIVE_LOW (de-asserted), `busy`=0, `dropped`=0
- First sampled edge after reset release behaves as from IDLE.

## Timing
- Trigger sampled at edge T from IDLE:
  - `level` asserted cycles T+1 .. T+WIDTH_CYCLES.
  - GAP cycles T+WIDTH_CYCLES+1 .. T+WIDTH_CYCLES+GAP_CYCLES.
  - IDLE from the following cycle.
- Retrigger sampled at edge R while ACTIVE: `level` continuously asserted through R+WIDTH_CYCLES.
- Pending trigger: `level` re-asserts on the first cycle after GAP ends, with no IDLE cycle in between.
- `dropped` asserts exactly 1 cycle after the ignored sample, for 1 cycle per ignored sample.
- Latency from trigger to `level` is 1 cycle. No combinational path from `pulse` to any output.

## Test plan
All cycle numbers are sampling edges. Defaults unless noted: WIDTH_CYCLES=16, GAP_CYCLES=4.

1. Single trigger: reset, then pulse=1 at cycle 10 only -> `level` high 11–26, `busy` high 11–30, `busy`=0 at 31, `dropped` never set.
2. Retrigger (RETRIGGER=1): pulses at 10 and 20 -> `level` high continuously 11–36, GAP 37–40, `dropped` never set.
3. No retrigger (RETRIGGER=0): pulses at 10 and 20 -> `level` high 11–26 only, `dropped`=1 at cycle 21 only.
4. Pending and overflow: pulses at 10, 28, 29 -> `level` high 11–26, low 27–30, high 31–46. `dropped`=1 at cycle 30 only.
5. Reset mid-operation: pulse at 10, reset asserted mid-cycle 15 -> `level`, `busy` de-assert immediately without waiting for clk. After release, a pulse at 30 -> `level` high 31–46.
6. Edge parameters (ACTIVE_LOW=1, GAP_CYCLES=0, WIDTH_CYCLES=1, RETRIGGER=1): pulse held 10–14 -> `level` low 11–15, high from 16, `busy`=0 at 16. Reset value of `level` is 1.

Source files
------------

// File: rtl/pulse_stretch.sv
// -----------------------------------------------------------------------------
// pulse_stretch
//
// Turns single-cycle event pulses into a level held for WIDTH_CYCLES cycles,
// followed by a de-asserted gap of at least GAP_CYCLES cycles. It is meant for
// LEDs, GPIO strobes and other slow observers of one-cycle events.
//
// Overlapping events are handled as follows:
//   - while asserted: reload the width (RETRIGGER=1), or drop the event.
//   - during the gap: hold one event as pending and start a new assertion
//     as soon as the gap ends; any further event is dropped.
//
// Ports
//   clk      in   single clock, rising edge
//   reset    in   asynchronous, active-high reset
//   pulse    in   trigger; every cycle it is high counts as one trigger
//   level    out  stretched output, asserted low when ACTIVE_LOW=1 (registered)
//   busy     out  high while asserting or in the gap (registered)
//   dropped  out  one-cycle flag, a trigger was discarded (registered)
// -----------------------------------------------------------------------------
module pulse_stretch #(
    parameter int WIDTH_CYCLES = 16,
    parameter int GAP_CYCLES   = 4,
    parameter bit RETRIGGER    = 1'b1,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pulse,
    output logic level,
    output logic busy,
    output logic dropped
);

    localparam int MAX_CYCLES = (WIDTH_CYCLES > GAP_CYCLES) ? WIDTH_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] WIDTH_LOAD = CNT_W'(WIDTH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             pending;
    logic             pending_nxt;
    logic             dropped_nxt;

    // Counter decrement that holds at zero instead of wrapping.
    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pending_nxt = pending;
        dropped_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (pulse) begin
                    state_nxt = ACTIVE;
                    cnt_nxt   = WIDTH_LOAD;
                end
            end

            ACTIVE: begin
                if (pulse && RETRIGGER) begin
                    // Reload takes priority even on the last active cycle,
                    // so the level never blinks off between triggers.
                    cnt_nxt = WIDTH_LOAD;
                end else begin
                    dropped_nxt = pulse;
                    if (cnt == '0) begin
                        if (GAP_CYCLES == 0) begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = GAP;
                            cnt_nxt   = GAP_LOAD;
                        end
                    end else begin
                        cnt_nxt = dec_sat(cnt);
                    end
                end
            end

            GAP: begin
                // Only one event can wait for the gap to finish; an event
                // arriving while one is already waiting is discarded.
                if (pulse && pending) begin
                    dropped_nxt = 1'b1;
                end
                if (cnt == '0) begin
                    if (pending || pulse) begin
                        state_nxt   = ACTIVE;
                        cnt_nxt     = WIDTH_LOAD;
                        pending_nxt = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = dec_sat(cnt);
                    if (pulse) begin
                        pending_nxt = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt   = IDLE;
                cnt_nxt     = '0;
                pending_nxt = 1'b0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state register and have no combinational path from pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= 1'b0;
            level   <= ACTIVE_LOW;
            busy    <= 1'b0;
            dropped <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pending <= pending_nxt;
            level   <= (state_nxt == ACTIVE) ^ ACTIVE_LOW;
            busy    <= (state_nxt != IDLE);
            dropped <= dropped_nxt;
        end
    end

endmodule
